// File: rtl/a5_decipher.sv
// a5_decipher: A5/1 stream decipher for one GSM burst.
// A start request captures the session key and frame number, then the block
// loads them into the three LFSRs, runs the discarded mixing steps and,
// for the uplink direction, skips the first keystream block. In RUN it XORs
// each accepted ciphertext bit with one keystream bit.
//
// Parameters:
//   DIRECTION  0 = first keystream block (downlink), 1 = second block (uplink)
//   BURSTLEN   keystream bits per block
//   MIXLEN     discarded majority-clocked mixing steps
// Ports:
//   i_clock, i_reset     rising-edge clock, asynchronous active-high reset
//   i_key[63:0]          session key Kc, bit 0 loaded first
//   i_frame[21:0]        frame number, bit 0 loaded first
//   i_start              one-cycle request to begin a burst (ignored while busy)
//   i_in_bit/i_in_valid  ciphertext bit and its qualifier
//   o_in_ready           high only in RUN
//   o_out_bit/o_out_valid  plaintext bit, valid one cycle after each transfer
//   o_busy               high in every state except IDLE
//   o_done               pulses with the final out_valid of the burst
module a5_decipher #(
    parameter int DIRECTION = 0,
    parameter int BURSTLEN  = 114,
    parameter int MIXLEN    = 100
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [63:0] i_key,
    input  logic [21:0] i_frame,
    input  logic        i_start,
    input  logic        i_in_bit,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_out_bit,
    output logic        o_out_valid,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_FRAME = 3'd2,
        MIX        = 3'd3,
        SKIP       = 3'd4,
        RUN        = 3'd5
    } state_t;

    localparam logic [6:0] KEY_LAST   = 7'd63;
    localparam logic [6:0] FRAME_LAST = 7'd21;
    localparam logic [6:0] MIX_LAST   = 7'(MIXLEN - 1);
    localparam logic [6:0] BURST_LAST = 7'(BURSTLEN - 1);
    localparam bit         USE_SKIP   = (DIRECTION == 32'sd1);

    // One LFSR step: shift toward the MSB, feedback (plus injected bit) into bit 0.
    function automatic logic [18:0] r1_step(input logic [18:0] r, input logic inj);
        r1_step = {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ inj};
    endfunction

    function automatic logic [21:0] r2_step(input logic [21:0] r, input logic inj);
        r2_step = {r[20:0], r[21] ^ r[20] ^ inj};
    endfunction

    function automatic logic [22:0] r3_step(input logic [22:0] r, input logic inj);
        r3_step = {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ inj};
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [18:0] r_r1;
    logic [21:0] r_r2;
    logic [22:0] r_r3;
    logic [63:0] r_key;
    logic [21:0] r_frame;
    logic        r_in_ready;
    logic        r_out_bit;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_ld_bit;
    logic        w_maj;
    logic [18:0] w_r1_ld;
    logic [21:0] w_r2_ld;
    logic [22:0] w_r3_ld;
    logic [18:0] w_r1_mj;
    logic [21:0] w_r2_mj;
    logic [22:0] w_r3_mj;
    logic        w_ks;

    // Next-register candidates: unconditional load step and majority step.
    always_comb begin
        w_ld_bit = 1'b0;
        if (r_state == LOAD_KEY) begin
            w_ld_bit = r_key[r_cnt[5:0]];
        end else begin
            w_ld_bit = r_frame[r_cnt[4:0]];
        end

        w_r1_ld = r1_step(r_r1, w_ld_bit);
        w_r2_ld = r2_step(r_r2, w_ld_bit);
        w_r3_ld = r3_step(r_r3, w_ld_bit);

        w_maj = maj3(r_r1[8], r_r2[10], r_r3[10]);

        w_r1_mj = r_r1;
        w_r2_mj = r_r2;
        w_r3_mj = r_r3;
        if (r_r1[8] == w_maj) begin
            w_r1_mj = r1_step(r_r1, 1'b0);
        end else begin
            w_r1_mj = r_r1;
        end
        if (r_r2[10] == w_maj) begin
            w_r2_mj = r2_step(r_r2, 1'b0);
        end else begin
            w_r2_mj = r_r2;
        end
        if (r_r3[10] == w_maj) begin
            w_r3_mj = r3_step(r_r3, 1'b0);
        end else begin
            w_r3_mj = r_r3;
        end

        // Keystream bit is taken from the registers as they will be after this step.
        w_ks = w_r1_mj[18] ^ w_r2_mj[21] ^ w_r3_mj[22];
    end

    // Control FSM, LFSR state, captured key/frame and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= 7'd0;
            r_r1        <= 19'd0;
            r_r2        <= 22'd0;
            r_r3        <= 23'd0;
            r_key       <= 64'd0;
            r_frame     <= 22'd0;
            r_in_ready  <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_key   <= i_key;
                        r_frame <= i_frame;
                        r_r1    <= 19'd0;
                        r_r2    <= 22'd0;
                        r_r3    <= 23'd0;
                        r_cnt   <= 7'd0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD_KEY;
                    end
                end
                LOAD_KEY: begin
                    r_r1 <= w_r1_ld;
                    r_r2 <= w_r2_ld;
                    r_r3 <= w_r3_ld;
                    if (r_cnt == KEY_LAST) begin
                        r_cnt   <= 7'd0;
                        r_state <= LOAD_FRAME;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                LOAD_FRAME: begin
                    r_r1 <= w_r1_ld;
                    r_r2 <= w_r2_ld;
                    r_r3 <= w_r3_ld;
                    if (r_cnt == FRAME_LAST) begin
                        r_cnt   <= 7'd0;
                        r_state <= MIX;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                MIX, SKIP: begin
                    r_r1 <= w_r1_mj;
                    r_r2 <= w_r2_mj;
                    r_r3 <= w_r3_mj;
                    if ((r_state == MIX && r_cnt == MIX_LAST) ||
                        (r_state == SKIP && r_cnt == BURST_LAST)) begin
                        r_cnt <= 7'd0;
                        // Uplink discards one whole block before the usable one.
                        if (r_state == MIX && USE_SKIP) begin
                            r_state <= SKIP;
                        end else begin
                            r_state    <= RUN;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                RUN: begin
                    if (i_in_valid) begin
                        r_r1        <= w_r1_mj;
                        r_r2        <= w_r2_mj;
                        r_r3        <= w_r3_mj;
                        r_out_bit   <= i_in_bit ^ w_ks;
                        r_out_valid <= 1'b1;
                        if (r_cnt == BURST_LAST) begin
                            r_cnt      <= 7'd0;
                            r_state    <= IDLE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= 7'd0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_bit   = r_out_bit;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_a5_decipher.sv
// Bench for a5_decipher: one downlink (DIRECTION=0) and one uplink
// (DIRECTION=1) instance share all inputs. The driver pushes the expected
// plaintext bit for every transfer it issues; a monitor on the falling edge
// pops and compares whenever a DUT raises out_valid.
module tb_a5_decipher;

    localparam logic [63:0]  KEY    = 64'hEFCDAB8967452312;
    localparam logic [21:0]  FRAME  = 22'h134;
    localparam logic [119:0] KS0HEX = 120'h534EAA582FE8151AB6E1855A728C00;
    localparam logic [119:0] KS1HEX = 120'h24FD35A35D5FB6526D32F906DF1AC0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key = KEY;
    logic [21:0] frame = FRAME;
    logic        start = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;

    logic rdy0, ob0, ov0, busy0, done0;
    logic rdy1, ob1, ov1, busy1, done1;

    logic [119:0] ks0;
    logic [119:0] ks1;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int idx0, idx1, nov0, nov1, done_at0, done_at1, first0, first1;
    int gap_done0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] e0, e1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    a5_decipher #(.DIRECTION(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_key(key), .i_frame(frame),
        .i_start(start), .i_in_bit(in_bit), .i_in_valid(in_valid),
        .o_in_ready(rdy0), .o_out_bit(ob0), .o_out_valid(ov0),
        .o_busy(busy0), .o_done(done0)
    );

    a5_decipher #(.DIRECTION(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_key(key), .i_frame(frame),
        .i_start(start), .i_in_bit(in_bit), .i_in_valid(in_valid),
        .o_in_ready(rdy1), .o_out_bit(ob1), .o_out_valid(ov1),
        .o_busy(busy1), .o_done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " d0 in_ready"}, 32'(rdy0), 32'd0);
        chk({tag, " d0 out_bit"}, 32'(ob0), 32'd0);
        chk({tag, " d0 out_valid"}, 32'(ov0), 32'd0);
        chk({tag, " d0 busy"}, 32'(busy0), 32'd0);
        chk({tag, " d0 done"}, 32'(done0), 32'd0);
        chk({tag, " d1 in_ready"}, 32'(rdy1), 32'd0);
        chk({tag, " d1 out_bit"}, 32'(ob1), 32'd0);
        chk({tag, " d1 out_valid"}, 32'(ov1), 32'd0);
        chk({tag, " d1 busy"}, 32'(busy1), 32'd0);
        chk({tag, " d1 done"}, 32'(done1), 32'd0);
    endtask

    // Monitor: pop the scoreboard on every out_valid, flag stray output.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov0) begin
                nov0++;
                if (q0.size() == 0) begin
                    chk("d0 unexpected out_valid", 32'd1, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk("d0 out_bit", 32'(ob0), 32'(e0[0]));
                    chk("d0 done", 32'(done0), 32'(e0[1]));
                    if (done0) done_at0 = cyc - t0;
                end
            end else begin
                chk("d0 done without out_valid", 32'(done0), 32'd0);
            end
            if (ov1) begin
                nov1++;
                if (q1.size() == 0) begin
                    chk("d1 unexpected out_valid", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("d1 out_bit", 32'(ob1), 32'(e1[0]));
                    chk("d1 done", 32'(done1), 32'(e1[1]));
                    if (done1) done_at1 = cyc - t0;
                end
            end else begin
                chk("d1 done without out_valid", 32'(done1), 32'd0);
            end
        end
    end

    // One burst on both DUTs. Edge numbers are relative to the edge that samples start.
    task automatic run_pass(input bit tog, input bit ciph, input bit spulse, input bit rst_mid);
        bit fin;
        int rel;
        @(posedge clk); #1;
        idx0 = 0; idx1 = 0; nov0 = 0; nov1 = 0;
        done_at0 = -1; done_at1 = -1; first0 = -1; first1 = -1;
        key = KEY; frame = FRAME; in_valid = 1'b0; in_bit = 1'b0;
        start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        if (spulse) begin
            key = ~KEY;
            frame = ~FRAME;
        end
        fin = 1'b0;
        for (int it = 0; it < 1200 && !fin; it++) begin
            rel = cyc - t0;
            if (rst_mid && rel + 1 == 250) begin
                rst = 1'b1;
                in_valid = 1'b0;
                q0.delete();
                q1.delete();
                fin = 1'b1;
            end else begin
                start = spulse && (rel + 1 == 50 || rel + 1 == 200);
                in_valid = tog ? ((rel + 1) % 2 == 1) : 1'b1;
                in_bit = (ciph && idx0 < 114) ? ks0[119 - idx0] : 1'b0;
                if (in_valid && rdy0) begin
                    if (first0 < 0) first0 = rel + 1;
                    if (idx0 < 114) q0.push_back({idx0 == 113, in_bit ^ ks0[119 - idx0]});
                    idx0++;
                end
                if (in_valid && rdy1) begin
                    if (first1 < 0) first1 = rel + 1;
                    if (idx1 < 114) q1.push_back({idx1 == 113, in_bit ^ ks1[119 - idx1]});
                    idx1++;
                end
                if (idx0 >= 114 && idx1 >= 114) fin = 1'b1;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!rst_mid) begin
            if (!fin) chk("pass timeout", 32'd1, 32'd0);
            repeat (4) @(posedge clk);
            #1;
            chk("d0 out_valid count", 32'(nov0), 32'd114);
            chk("d1 out_valid count", 32'(nov1), 32'd114);
            chk("d0 transfer count", 32'(idx0), 32'd114);
            chk("d1 transfer count", 32'(idx1), 32'd114);
            chk("d0 queue drained", 32'(q0.size()), 32'd0);
            chk("d1 queue drained", 32'(q1.size()), 32'd0);
            chk("d0 first transfer edge", 32'(first0), 32'd187);
            chk("d1 first transfer edge", 32'(first1), 32'd301);
        end
    endtask

    initial begin
        ks0 = KS0HEX;
        ks1 = KS1HEX;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Gap-free reference vector on both directions.
        run_pass(1'b0, 1'b0, 1'b0, 1'b0);
        gap_done0 = done_at0;
        chk("d0 done edge gap-free", 32'(done_at0), 32'd300);
        chk("d1 done edge gap-free", 32'(done_at1), 32'd414);

        // in_valid toggling: same bits, done 113 cycles later.
        run_pass(1'b1, 1'b0, 1'b0, 1'b0);
        chk("d0 done delay toggled", 32'(done_at0 - gap_done0), 32'd113);
        chk("d1 done edge toggled", 32'(done_at1), 32'd527);

        // Ciphertext equal to the downlink keystream decrypts to all zeros.
        run_pass(1'b0, 1'b1, 1'b0, 1'b0);
        chk("d0 done edge cipher", 32'(done_at0), 32'd300);

        // start pulses while busy and key/frame changes after capture are ignored.
        run_pass(1'b0, 1'b0, 1'b1, 1'b0);
        chk("d0 done edge restart-ignored", 32'(done_at0), 32'd300);

        // Reset mid-burst aborts; outputs clear immediately.
        run_pass(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk_outputs_zero("mid-reset");
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("mid-reset hold");
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("d0 idle after reset", 32'(busy0), 32'd0);
        chk("d1 idle after reset", 32'(busy1), 32'd0);
        in_valid = 1'b0;

        // New burst after reset reproduces the reference.
        run_pass(1'b0, 1'b0, 1'b0, 1'b0);
        chk("d0 done edge after reset", 32'(done_at0), 32'd300);
        chk("d1 done edge after reset", 32'(done_at1), 32'd414);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/a5_decipher.md
A5_DECIPHER -- requirements
Module: a5_decipher

Interface
REQ-001 Parameter DIRECTION, default 0, selects the keystream block: 0 uses the first 114 bits (downlink decrypt), 1 uses the second 114 bits (uplink).
REQ-002 Parameter BURSTLEN, default 114, gives the number of keystream bits per block.
REQ-003 Parameter MIXLEN, default 100, gives the number of discarded majority-clocked mixing steps.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 key  input  64  session key Kc; key[0] is applied first.
REQ-007 frame  input  22  frame number; frame[0] is applied first.
REQ-008 start  input  1  one-cycle request to begin a burst.
REQ-009 in_bit  input  1  received ciphertext bit.
REQ-010 in_valid  input  1  in_bit is valid.
REQ-011 in_ready  output  1  block accepts in_bit this cycle.
REQ-012 out_bit  output  1  plaintext bit (in_bit XOR keystream).
REQ-013 out_valid  output  1  out_bit is valid; a one-cycle pulse per accepted bit.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on the final output bit of the burst.

Function
REQ-016 The block SHALL hold R1 (19 bits), R2 (22 bits) and R3 (23 bits).
- Feedback taps: R1 bits 18,17,16,13; R2 bits 21,20; R3 bits 22,21,20,7.
- A step shifts each register toward its MSB and writes the XOR of its taps into bit 0.
REQ-017 Sync bits SHALL be R1[8], R2[10] and R3[10].
- Majority step: m = majority of the three sync bits.
- Only registers whose sync bit equals m step.
REQ-018 The keystream bit SHALL be R1[18]^R2[21]^R3[22], evaluated on the register values after the step that produced it.
REQ-019 FSM states SHALL be IDLE, LOAD_KEY, LOAD_FRAME, MIX, SKIP, RUN; a 7-bit counter times each state.
REQ-020 IDLE: start=1 SHALL capture key and frame, zero R1/R2/R3, clear the counter and enter LOAD_KEY.
REQ-021 LOAD_KEY: for 64 cycles, all three registers SHALL step unconditionally, with key[i] XORed into bit 0 of each.
REQ-022 LOAD_FRAME: the same procedure SHALL be applied for 22 cycles using frame[i].
REQ-023 MIX: for MIXLEN cycles, registers SHALL take majority steps with the output discarded.
- Next state is SKIP if DIRECTION=1, otherwise RUN.
REQ-024 SKIP: for BURSTLEN cycles, registers SHALL take majority steps with the output discarded, then enter RUN.
REQ-025 RUN: in_ready SHALL be 1.
- Each cycle with in_valid=1 is one transfer and causes one majority step.
- in_valid=0 freezes the registers and the counter.
REQ-026 Each transfer SHALL produce out_bit = in_bit XOR keystream and out_valid=1 on the following cycle (latency 1).
- Throughput is one bit per cycle.
REQ-027 On the BURSTLEN-th transfer, the FSM SHALL return to IDLE and done SHALL pulse together with the last out_valid.
REQ-028 start SHALL be ignored while busy=1.
- key and frame changes after capture have no effect on the current burst.
REQ-029 in_ready SHALL be 0 outside RUN, and in_valid is ignored there.
REQ-030 Timing, with start sampled at edge 0:
- DIRECTION=0: first in_ready is high in cycle 187.
- DIRECTION=1: first in_ready is high in cycle 301.
REQ-031 start and a final transfer SHALL NOT coincide, because busy is still 1 during the final transfer; a start in the cycle after done SHALL be accepted.

Reset
REQ-032 While reset=1, the state SHALL be IDLE and the counter, R1, R2, R3 and the captured key and frame SHALL be zero.
REQ-033 Reset values of all outputs SHALL be: in_ready=0, out_bit=0, out_valid=0, busy=0, done=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no further out_valid.
- After release, a new start is required.

Verification
REQ-035 Test vector, DIRECTION=0: key=64'hEFCDAB8967452312, frame=22'h134, in_bit=0, in_valid=1 continuously.
- out_bit sequence SHALL equal keystream hex 534EAA582FE8151AB6E1855A728C00, MSB first (first 8 bits 01010011).
- Exactly 114 out_valid pulses SHALL occur, with done on the last.
REQ-036 Same vector with DIRECTION=1 -> out_bit sequence SHALL equal 24FD35A35D5FB6526D32F906DF1AC0, MSB first (first 8 bits 00100100).
REQ-037 REQ-035 vector with in_valid toggling 1/0 every cycle -> the same 114 bits SHALL appear, and done SHALL occur 113 cycles later than in the gap-free run.
REQ-038 Ciphertext equal to the REQ-035 keystream -> all 114 out_bit values SHALL be 0.
REQ-039 start pulsed again in cycle 50 and in cycle 200 -> both pulses SHALL be ignored and the output SHALL be identical to REQ-035.
REQ-040 reset asserted in cycle 250, then start -> all outputs SHALL be 0 during reset, and the new burst SHALL reproduce REQ-035 exactly.
